ercmd_fetch: RTL

ERCMD_FETCH -- requirements
Module: ercmd_fetch

---
 rtl/ercmd_fetch_pkg.sv | 18 +
 rtl/ercmd_fifo.sv | 49 ++++
 rtl/ercmd_fetch.sv | 108 ++++++++++
 3 files changed

// File: rtl/ercmd_fetch_pkg.sv
// Shared Earthrise command-list definitions: opcode field layout, STOP value,
// fetcher state encoding and command buffer sizing.
package ercmd_fetch_pkg;

  // Opcode occupies the top OPC_W bits of every command word.
  localparam int OPC_W = 8;
  localparam logic [OPC_W-1:0] OPC_STOP = 8'h00;

  localparam int FIFO_DEPTH = 4;
  localparam int FIFO_CW    = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/ercmd_fifo.sv
// Small synchronous FIFO for the Earthrise command stream; storage is not reset,
// only pointers and occupancy. Flush empties it in one cycle.
module ercmd_fifo #(
  parameter int WORD  = 32,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            push,
  input  logic [WORD-1:0] push_data,
  input  logic            pop,
  output logic            valid,
  output logic [WORD-1:0] data,
  output logic [CW-1:0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [WORD-1:0] mem [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign valid = (count != '0);
  assign data  = mem[rd_ptr];

endmodule

// File: rtl/ercmd_fetch.sv
// Earthrise command-list fetcher: reads a STOP-terminated list from a 2-cycle
// latency memory and streams the commands through a 4-entry buffer.
module ercmd_fetch
  import ercmd_fetch_pkg::*;
#(
  parameter int WORD  = 32,
  parameter int ADDRW = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [ADDRW-1:0] start_addr,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [ADDRW-1:0] addr_er,
  input  logic [WORD-1:0]  dout_er,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic [WORD-1:0]  cmd_data
);

  localparam int LW = FIFO_CW + 1;

  fetch_state_t       state;
  logic [1:0]         inflight;
  logic [FIFO_CW-1:0] fifo_count;
  logic [LW-1:0]      load;
  logic pop, capture, is_stop, stop_seen, push, issue;

  assign pop       = cmd_valid & cmd_ready;
  assign capture   = inflight[1] && (state == ST_RUN);
  assign is_stop   = (dout_er[WORD-1 -: OPC_W] == OPC_STOP);
  assign stop_seen = capture && is_stop;
  assign push      = capture && !is_stop && !abort;

  // Occupancy after this cycle's pop, plus reads still in the memory pipe, plus this read.
  assign load  = LW'(fifo_count) - LW'(pop) + LW'(inflight[0]) + LW'(inflight[1]) + LW'(1);
  assign issue = (state == ST_RUN) && !stop_seen && !abort && (load <= LW'(FIFO_DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      inflight <= '0;
      addr_er  <= '0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state    <= ST_IDLE;
        busy     <= 1'b0;
        inflight <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            inflight <= '0;
            if (start) begin
              state   <= ST_RUN;
              busy    <= 1'b1;
              addr_er <= start_addr;
            end
          end
          ST_RUN: begin
            // Reads already in flight past STOP are speculative: drop their valid bits.
            if (stop_seen) begin
              state    <= ST_DRAIN;
              inflight <= '0;
            end else begin
              inflight <= {inflight[0], issue};
              if (issue) addr_er <= addr_er + ADDRW'(1);
            end
          end
          ST_DRAIN: begin
            inflight <= '0;
            if (fifo_count == '0) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
          default: begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            inflight <= '0;
          end
        endcase
      end
    end
  end

  ercmd_fifo #(
    .WORD  (WORD),
    .DEPTH (FIFO_DEPTH),
    .CW    (FIFO_CW)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (abort),
    .push      (push),
    .push_data (dout_er),
    .pop       (pop),
    .valid     (cmd_valid),
    .data      (cmd_data),
    .count     (fifo_count)
  );

endmodule
